imul_simd_pipe: RTL and testbench
=================================

Name: imul_simd_pipe

Overview:
- Parametrised, fully pipelined integer multiplier; next generation of the ALU-cluster multiply unit.
- Generalised in operand width, pipeline depth and SIMD lane count (1, 2 or 4 lanes).
- Adds in-order valid/tag tracking, stall via clkEn and flush of in-flight ops.
- Returns the low or high product half with x86-style flags to the writeback mux.

Parameters:
- WIDTH, 64, operand/result width; power of two, >=32, divisible by 4.
- STAGES, 3, issue-to-result latency in enabled cycles; legal range 2..5.
- TAG_W, 9, width of the opaque destination tag carried alongside each op.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- clkEn  in  1  pipeline advance; when low, every stage holds, including valids, tags and data
- flush  in  1  kill all in-flight ops
- in_en  in  1  issue an op this cycle
- in_op  in  6  [2:0] kind: 0 MUL_LO, 1 MUL_HI, 2 IMUL_LO, 3 IMUL_HI, 4 MULSU_HI; [5:4] lanes: 00 = 1 lane, 01 = 2 lanes, 10 = 4 lanes, 11 reserved
- in_R  in  WIDTH  multiplicand; in_R is signed for MULSU_HI
- in_C  in  WIDTH  multiplier; in_C is unsigned for MULSU_HI
- in_tag  in  TAG_W  destination tag
- out_en  out  1  result valid
- out_Res  out  WIDTH  result, packed per lane
- out_tag  out  TAG_W  tag of the returned op
- out_flg  out  6  {CF, OF, 1'b0, SF, ZF, PF}

Behaviour:
- Reset: all stage valids, out_en, out_Res, out_tag and out_flg go to 0 on the first rising edge with rst=1. Reset wins over clkEn and flush. Ops in flight during reset are discarded.
- Issue: an op is accepted only when in_en && clkEn && ~flush. There is no back-pressure; one op can be accepted every enabled cycle.
- Latency: an op accepted at enabled edge N appears with out_en=1 after STAGES enabled edges. Cycles with clkEn low do not count and leave the outputs unchanged.
- Ordering: results return strictly in order with their own tag. out_en is a single-cycle pulse per op unless clkEn is low, in which case it is held.
- Flush: when flush=1 with clkEn=1, all stage valids clear and out_en=0 at the next edge. An op issued in the same cycle is dropped. Flush with clkEn=0 has no effect.
- Lanes: the lane width is L = WIDTH/lanes. Each lane multiplies R[L*i+:L] by C[L*i+:L] into a 2L-bit product P_i.
  - *_LO ops return P_i[L-1:0] in lane i.
  - *_HI ops return P_i[2L-1:L] in lane i.
  - Signedness per kind: MUL unsigned x unsigned, IMUL signed x signed, MULSU signed R x unsigned C.
- Reserved lanes code (11) is treated as 1 lane, and kind codes 5..7 are treated as MUL_LO. No error is signalled.
- Flags, per op:
  - CF = OF = OR over lanes of "P_i does not fit in L bits". For unsigned kinds that means the upper half is non-zero. For signed kinds it means the upper half is not the sign extension of bit L-1 of the lower half.
  - SF = MSB of out_Res.
  - ZF = (out_Res == 0).
  - PF = even parity of out_Res[7:0].
  - Bit 3 is always 0.
- Width rule: no intermediate truncation. Each lane product is formed at full 2L bits before the half is selected.
- Stage allocation:
  - Stage 1 registers the operands and decoded controls.
  - The middle stages hold partial sums; for STAGES=2 these collapse into the final stage.
  - The final stage performs the carry-propagate add, half selection and flags.
  - Any retiming that meets the latency rule is acceptable.

Decomposition:
- Shared package imul_pkg:
  - op kind localparams: IMUL_K_MUL_LO, IMUL_K_MUL_HI, IMUL_K_IMUL_LO, IMUL_K_IMUL_HI, IMUL_K_MULSU_HI;
  - lane codes IMUL_LN_1, IMUL_LN_2, IMUL_LN_4;
  - flag bit indices IMUL_FLG_CF..IMUL_FLG_PF.
- One sub-module, imul_lane_mul: a segmented WIDTH x WIDTH multiplier that masks cross-lane partial products according to the lane code and applies per-lane sign correction.
- The top level owns the valid/tag shift chain, clkEn and flush handling, half selection and flag logic.

Test Plan:
1. WIDTH=64, STAGES=3. MUL_LO with R=0xFFFF_FFFF_FFFF_FFFF, C=2, tag 0x15 -> 3 edges later out_en=1, out_Res=0xFFFF_FFFF_FFFF_FFFE, out_tag=0x15, CF=OF=1, SF=1, ZF=0, PF=0.
2. IMUL_HI with R=C=0xFFFF_FFFF_FFFF_FFFF (-1 x -1) -> out_Res=0, ZF=1, PF=1, CF=OF=0. The same operands with MUL_HI -> out_Res=0xFFFF_FFFF_FFFF_FFFE, CF=OF=1.
3. 2 lanes, MUL_LO, R=0x0000_0003_FFFF_FFFF, C=0x0000_0005_0000_0002 -> out_Res=0x0000_000F_FFFF_FFFE, CF=1 (from lane 0).
4. Back-to-back issue of tags 1,2,3 with clkEn low for 2 cycles in the middle -> tags return 1,2,3 in order. Each is delayed by exactly 2 cycles, and out_* hold steady while clkEn is low.
5. Issue tags 4 and 5, then assert flush together with in_en carrying tag 6 -> out_en stays 0 for the next STAGES+1 cycles. A later issue of tag 7 returns normally.
6. Assert rst for one edge while 3 ops are in flight (clkEn=1) -> out_en=0 and out_Res=0 from the next edge on, and no stale result ever appears.

Source files
------------

// File: rtl/imul_simd_pipe_pkg.sv
// Shared encodings for the SIMD integer multiply pipeline: op kinds, lane
// codes, flag bit positions and small decode/parity helpers.
package imul_pkg;

    localparam logic [2:0] IMUL_K_MUL_LO   = 3'd0;
    localparam logic [2:0] IMUL_K_MUL_HI   = 3'd1;
    localparam logic [2:0] IMUL_K_IMUL_LO  = 3'd2;
    localparam logic [2:0] IMUL_K_IMUL_HI  = 3'd3;
    localparam logic [2:0] IMUL_K_MULSU_HI = 3'd4;

    localparam logic [1:0] IMUL_LN_1 = 2'b00;
    localparam logic [1:0] IMUL_LN_2 = 2'b01;
    localparam logic [1:0] IMUL_LN_4 = 2'b10;

    localparam int IMUL_FLG_CF = 5;
    localparam int IMUL_FLG_OF = 4;
    localparam int IMUL_FLG_SF = 2;
    localparam int IMUL_FLG_ZF = 1;
    localparam int IMUL_FLG_PF = 0;

    function automatic logic parity_even8(input logic [7:0] v);
        return ~(^v);
    endfunction

    function automatic logic kind_is_hi(input logic [2:0] k);
        return (k == IMUL_K_MUL_HI) || (k == IMUL_K_IMUL_HI) || (k == IMUL_K_MULSU_HI);
    endfunction

    // The multiplicand is signed for both IMUL kinds and for MULSU.
    function automatic logic kind_r_signed(input logic [2:0] k);
        return (k == IMUL_K_IMUL_LO) || (k == IMUL_K_IMUL_HI) || (k == IMUL_K_MULSU_HI);
    endfunction

    function automatic logic kind_c_signed(input logic [2:0] k);
        return (k == IMUL_K_IMUL_LO) || (k == IMUL_K_IMUL_HI);
    endfunction

endpackage

// File: rtl/imul_simd_pipe_lane_mul.sv
// Segmented WIDTH x WIDTH multiplier built from quarter-width sub-products;
// lane i's full 2L-bit product lands at bits [2L*i +: 2L] of prod.
module imul_lane_mul
    import imul_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               a_sgn,
    input  logic               b_sgn,
    input  logic [1:0]         ln,
    output logic [2*WIDTH-1:0] prod
);

    localparam int Q = WIDTH / 4;

    logic [1:0]         seg_sh_s;
    logic [2*Q-1:0]     pp_s;
    logic [2*WIDTH-1:0] uprod_s;

    // Quarter chunks i and j belong to the same lane when (i >> seg_sh) == (j >> seg_sh).
    always_comb begin
        case (ln)
            IMUL_LN_2: seg_sh_s = 2'd1;
            IMUL_LN_4: seg_sh_s = 2'd0;
            default:   seg_sh_s = 2'd2;
        endcase
    end

    // Sum only same-lane sub-products; each lane's result stays inside its 2L field.
    always_comb begin
        uprod_s = {(2*WIDTH){1'b0}};
        pp_s    = {(2*Q){1'b0}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if ((i >> seg_sh_s) == (j >> seg_sh_s)) begin
                    pp_s    = {{Q{1'b0}}, a[Q*i +: Q]} * {{Q{1'b0}}, b[Q*j +: Q]};
                    uprod_s = uprod_s + ({{(2*WIDTH-2*Q){1'b0}}, pp_s} << (Q*(i+j)));
                end else begin
                    uprod_s = uprod_s;
                end
            end
        end
    end

    // Signed correction per lane: a negative operand subtracts the other operand shifted by L.
    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int NL = 1 << m;
        localparam int LW = WIDTH / NL;
        logic [2*WIDTH-1:0] fix_s;
        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic [2*LW-1:0] corr_a_s;
            logic [2*LW-1:0] corr_b_s;
            assign corr_a_s = (a_sgn && a[LW*k+LW-1]) ? {b[LW*k +: LW], {LW{1'b0}}} : {(2*LW){1'b0}};
            assign corr_b_s = (b_sgn && b[LW*k+LW-1]) ? {a[LW*k +: LW], {LW{1'b0}}} : {(2*LW){1'b0}};
            assign fix_s[2*LW*k +: 2*LW] = uprod_s[2*LW*k +: 2*LW] - corr_a_s - corr_b_s;
        end
    end

    // Pick the correction set matching the active lane split.
    always_comb begin
        case (ln)
            IMUL_LN_2: prod = g_mode[1].fix_s;
            IMUL_LN_4: prod = g_mode[2].fix_s;
            default:   prod = g_mode[0].fix_s;
        endcase
    end

endmodule

// File: rtl/imul_simd_pipe.sv
// Pipelined SIMD integer multiplier: operand stage, product stages, then
// half selection and x86-style flags, with in-order valid/tag tracking.
module imul_simd_pipe
    import imul_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 3,
    parameter int TAG_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  logic             flush,
    input  logic             in_en,
    input  logic [5:0]       in_op,
    input  logic [WIDTH-1:0] in_R,
    input  logic [WIDTH-1:0] in_C,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_en,
    output logic [WIDTH-1:0] out_Res,
    output logic [TAG_W-1:0] out_tag,
    output logic [5:0]       out_flg
);

    logic             s1_v_q,    s1_v_d;
    logic [TAG_W-1:0] s1_tag_q,  s1_tag_d;
    logic [2:0]       s1_kind_q, s1_kind_d;
    logic [1:0]       s1_ln_q,   s1_ln_d;
    logic [WIDTH-1:0] s1_r_q,    s1_r_d;
    logic [WIDTH-1:0] s1_c_q,    s1_c_d;

    logic             out_en_q,  out_en_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [5:0]       out_flg_q, out_flg_d;

    logic               accept_s;
    logic               unused_op_s;
    logic [2*WIDTH-1:0] prod_s;

    logic               fin_v_s;
    logic [TAG_W-1:0]   fin_tag_s;
    logic [2:0]         fin_kind_s;
    logic [1:0]         fin_ln_s;
    logic [2*WIDTH-1:0] fin_prod_s;
    logic               fin_sgn_s;

    logic [WIDTH-1:0] sel_lo_s, sel_hi_s, res_s;
    logic             ovf_s;
    logic [5:0]       flg_s;

    assign accept_s    = in_en && clkEn && !flush;
    assign unused_op_s = in_op[3];

    // Operand stage: reserved lane/kind codes are folded to 1 lane / MUL_LO here.
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_tag_d  = s1_tag_q;
        s1_kind_d = s1_kind_q;
        s1_ln_d   = s1_ln_q;
        s1_r_d    = s1_r_q;
        s1_c_d    = s1_c_q;
        if (clkEn) begin
            s1_v_d = accept_s;
            if (accept_s) begin
                s1_tag_d  = in_tag;
                s1_kind_d = (in_op[2:0] > IMUL_K_MULSU_HI) ? IMUL_K_MUL_LO : in_op[2:0];
                s1_ln_d   = (in_op[5:4] == 2'b11) ? IMUL_LN_1 : in_op[5:4];
                s1_r_d    = in_R;
                s1_c_d    = in_C;
            end else begin
                s1_tag_d  = s1_tag_q;
            end
        end else begin
            s1_v_d = s1_v_q;
        end
    end

    imul_lane_mul #(.WIDTH(WIDTH)) u_mul (
        .a     (s1_r_q),
        .b     (s1_c_q),
        .a_sgn (kind_r_signed(s1_kind_q)),
        .b_sgn (kind_c_signed(s1_kind_q)),
        .ln    (s1_ln_q),
        .prod  (prod_s)
    );

    if (STAGES > 2) begin : g_mid
        localparam int NM = STAGES - 2;
        logic [NM-1:0]                v_q,    v_d;
        logic [NM-1:0][TAG_W-1:0]     tag_q,  tag_d;
        logic [NM-1:0][2:0]           kind_q, kind_d;
        logic [NM-1:0][1:0]           ln_q,   ln_d;
        logic [NM-1:0][2*WIDTH-1:0]   prod_q, prod_d;

        // Product delay chain; valids are killed by flush, data just shifts.
        always_comb begin
            v_d    = v_q;
            tag_d  = tag_q;
            kind_d = kind_q;
            ln_d   = ln_q;
            prod_d = prod_q;
            if (clkEn) begin
                v_d[0]    = s1_v_q && !flush;
                tag_d[0]  = s1_tag_q;
                kind_d[0] = s1_kind_q;
                ln_d[0]   = s1_ln_q;
                prod_d[0] = prod_s;
                for (int i = 1; i < NM; i++) begin
                    v_d[i]    = v_q[i-1] && !flush;
                    tag_d[i]  = tag_q[i-1];
                    kind_d[i] = kind_q[i-1];
                    ln_d[i]   = ln_q[i-1];
                    prod_d[i] = prod_q[i-1];
                end
            end else begin
                v_d = v_q;
            end
        end

        // Middle stage registers.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= '0;
                tag_q  <= '0;
                kind_q <= '0;
                ln_q   <= '0;
                prod_q <= '0;
            end else begin
                v_q    <= v_d;
                tag_q  <= tag_d;
                kind_q <= kind_d;
                ln_q   <= ln_d;
                prod_q <= prod_d;
            end
        end

        assign fin_v_s    = v_q[NM-1];
        assign fin_tag_s  = tag_q[NM-1];
        assign fin_kind_s = kind_q[NM-1];
        assign fin_ln_s   = ln_q[NM-1];
        assign fin_prod_s = prod_q[NM-1];
    end else begin : g_nomid
        assign fin_v_s    = s1_v_q;
        assign fin_tag_s  = s1_tag_q;
        assign fin_kind_s = s1_kind_q;
        assign fin_ln_s   = s1_ln_q;
        assign fin_prod_s = prod_s;
    end

    assign fin_sgn_s = kind_r_signed(fin_kind_s);

    // Per-lane halves and "product does not fit in L bits" for each lane split.
    for (genvar m = 0; m < 3; m++) begin : g_sel
        localparam int NL = 1 << m;
        localparam int LW = WIDTH / NL;
        logic [WIDTH-1:0] lo_s;
        logic [WIDTH-1:0] hi_s;
        logic [NL-1:0]    ov_s;
        for (genvar k = 0; k < NL; k++) begin : g_lane
            assign lo_s[LW*k +: LW] = fin_prod_s[2*LW*k +: LW];
            assign hi_s[LW*k +: LW] = fin_prod_s[2*LW*k+LW +: LW];
            assign ov_s[k] = fin_sgn_s ? (hi_s[LW*k +: LW] != {LW{lo_s[LW*k+LW-1]}})
                                       : (hi_s[LW*k +: LW] != {LW{1'b0}});
        end
    end

    // Half selection and flag generation for the retiring op.
    always_comb begin
        case (fin_ln_s)
            IMUL_LN_2: begin sel_lo_s = g_sel[1].lo_s; sel_hi_s = g_sel[1].hi_s; ovf_s = |g_sel[1].ov_s; end
            IMUL_LN_4: begin sel_lo_s = g_sel[2].lo_s; sel_hi_s = g_sel[2].hi_s; ovf_s = |g_sel[2].ov_s; end
            default:   begin sel_lo_s = g_sel[0].lo_s; sel_hi_s = g_sel[0].hi_s; ovf_s = |g_sel[0].ov_s; end
        endcase
        res_s              = kind_is_hi(fin_kind_s) ? sel_hi_s : sel_lo_s;
        flg_s              = 6'b000000;
        flg_s[IMUL_FLG_CF] = ovf_s;
        flg_s[IMUL_FLG_OF] = ovf_s;
        flg_s[IMUL_FLG_SF] = res_s[WIDTH-1];
        flg_s[IMUL_FLG_ZF] = (res_s == {WIDTH{1'b0}});
        flg_s[IMUL_FLG_PF] = parity_even8(res_s[7:0]);
    end

    // Output stage: out_en pulses per op; data only changes on a valid result.
    always_comb begin
        out_en_d  = out_en_q;
        out_res_d = out_res_q;
        out_tag_d = out_tag_q;
        out_flg_d = out_flg_q;
        if (clkEn) begin
            out_en_d = fin_v_s && !flush;
            if (fin_v_s && !flush) begin
                out_res_d = res_s;
                out_tag_d = fin_tag_s;
                out_flg_d = flg_s;
            end else begin
                out_res_d = out_res_q;
            end
        end else begin
            out_en_d = out_en_q;
        end
    end

    // Operand and output stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_tag_q  <= '0;
            s1_kind_q <= 3'd0;
            s1_ln_q   <= 2'b00;
            s1_r_q    <= '0;
            s1_c_q    <= '0;
            out_en_q  <= 1'b0;
            out_res_q <= '0;
            out_tag_q <= '0;
            out_flg_q <= 6'b000000;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_tag_q  <= s1_tag_d;
            s1_kind_q <= s1_kind_d;
            s1_ln_q   <= s1_ln_d;
            s1_r_q    <= s1_r_d;
            s1_c_q    <= s1_c_d;
            out_en_q  <= out_en_d;
            out_res_q <= out_res_d;
            out_tag_q <= out_tag_d;
            out_flg_q <= out_flg_d;
        end
    end

    assign out_en  = out_en_q;
    assign out_Res = out_res_q;
    assign out_tag = out_tag_q;
    assign out_flg = out_flg_q;

endmodule

// File: tb/tb_imul_simd_pipe.sv
// Directed bench for imul_simd_pipe (WIDTH=64, STAGES=3) with hand-computed results.
module tb_imul_simd_pipe;

    logic        clk = 1'b0;
    logic        rst, clkEn, flush, in_en;
    logic [5:0]  in_op;
    logic [63:0] in_R, in_C;
    logic [8:0]  in_tag;
    logic        out_en;
    logic [63:0] out_Res;
    logic [8:0]  out_tag;
    logic [5:0]  out_flg;

    int n_pass  = 0;
    int n_total = 0;

    imul_simd_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(9)) dut (
        .clk     (clk),
        .rst     (rst),
        .clkEn   (clkEn),
        .flush   (flush),
        .in_en   (in_en),
        .in_op   (in_op),
        .in_R    (in_R),
        .in_C    (in_C),
        .in_tag  (in_tag),
        .out_en  (out_en),
        .out_Res (out_Res),
        .out_tag (out_tag),
        .out_flg (out_flg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", nm, obs, exp);
    endtask

    function automatic logic [5:0] mkop(input logic [1:0] ln, input logic [2:0] k);
        return {ln, 1'b0, k};
    endfunction

    task automatic run_op(input string nm, input logic [5:0] op, input logic [63:0] r,
                          input logic [63:0] c, input logic [8:0] tag,
                          input logic [63:0] er, input logic [5:0] ef);
        in_en = 1'b1; in_op = op; in_R = r; in_C = c; in_tag = tag;
        step();
        in_en = 1'b0;
        step();
        chk({nm, "_early"}, {63'd0, out_en}, 64'd0);
        step();
        chk({nm, "_en"},  {63'd0, out_en},  64'd1);
        chk({nm, "_res"}, out_Res,          er);
        chk({nm, "_tag"}, {55'd0, out_tag}, {55'd0, tag});
        chk({nm, "_flg"}, {58'd0, out_flg}, {58'd0, ef});
        step();
        chk({nm, "_pulse"}, {63'd0, out_en}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; clkEn = 1'b1; flush = 1'b0; in_en = 1'b0;
        in_op = 6'd0; in_R = 64'd0; in_C = 64'd0; in_tag = 9'd0;
        step();
        chk("rst_en",  {63'd0, out_en},  64'd0);
        chk("rst_res", out_Res,          64'd0);
        chk("rst_tag", {55'd0, out_tag}, 64'd0);
        chk("rst_flg", {58'd0, out_flg}, 64'd0);
        rst = 1'b0;
        step();

        run_op("mul_lo", mkop(2'b00, 3'd0), 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 9'h015,
               64'hFFFF_FFFF_FFFF_FFFE, 6'h34);
        run_op("imul_hi", mkop(2'b00, 3'd3), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'h021,
               64'h0000_0000_0000_0000, 6'h03);
        run_op("mul_hi", mkop(2'b00, 3'd1), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'h022,
               64'hFFFF_FFFF_FFFF_FFFE, 6'h34);
        run_op("ln2_lo", mkop(2'b01, 3'd0), 64'h0000_0003_FFFF_FFFF, 64'h0000_0005_0000_0002, 9'h031,
               64'h0000_000F_FFFF_FFFE, 6'h30);
        run_op("ln4_ilo", mkop(2'b10, 3'd2), 64'hFFFF_0002_8000_0003, 64'h0002_FFFF_0002_0004, 9'h041,
               64'hFFFE_FFFE_0000_000C, 6'h35);
        run_op("mulsu_hi", mkop(2'b00, 3'd4), 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 9'h051,
               64'hFFFF_FFFF_FFFF_FFFF, 6'h35);
        run_op("reserved", 6'b110111, 64'd3, 64'd5, 9'h1FF, 64'd15, 6'h01);

        // In-order return across a 2-cycle stall
        in_en = 1'b1; in_op = mkop(2'b00, 3'd0); in_C = 64'd3;
        in_R = 64'd1; in_tag = 9'd1; step();
        in_R = 64'd2; in_tag = 9'd2; step();
        in_R = 64'd3; in_tag = 9'd3; clkEn = 1'b0;
        step(); chk("stall_a_en", {63'd0, out_en}, 64'd0);
        step(); chk("stall_b_en", {63'd0, out_en}, 64'd0);
        clkEn = 1'b1; step(); in_en = 1'b0;
        chk("ord1_en",  {63'd0, out_en},  64'd1);
        chk("ord1_tag", {55'd0, out_tag}, 64'd1);
        chk("ord1_res", out_Res,          64'd3);
        clkEn = 1'b0; step();
        chk("hold_en",  {63'd0, out_en},  64'd1);
        chk("hold_tag", {55'd0, out_tag}, 64'd1);
        chk("hold_res", out_Res,          64'd3);
        clkEn = 1'b1; step();
        chk("ord2_tag", {55'd0, out_tag}, 64'd2);
        chk("ord2_res", out_Res,          64'd6);
        step();
        chk("ord3_en",  {63'd0, out_en},  64'd1);
        chk("ord3_tag", {55'd0, out_tag}, 64'd3);
        chk("ord3_res", out_Res,          64'd9);
        step();
        chk("ord_end_en", {63'd0, out_en}, 64'd0);

        // Flush kills in-flight ops and the op issued alongside it
        in_en = 1'b1; in_R = 64'd4; in_tag = 9'd4; step();
        in_R = 64'd5; in_tag = 9'd5; step();
        in_R = 64'd6; in_tag = 9'd6; flush = 1'b1; step();
        flush = 1'b0; in_en = 1'b0;
        chk("flush_en0", {63'd0, out_en}, 64'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("flush_en", {63'd0, out_en}, 64'd0);
        end
        run_op("post_flush", mkop(2'b00, 3'd0), 64'd7, 64'd3, 9'd7, 64'd21, 6'h00);

        // Reset with ops in flight
        in_en = 1'b1; in_R = 64'd8; in_tag = 9'd8; step();
        in_R = 64'd9; in_tag = 9'd9; step();
        in_R = 64'd10; in_tag = 9'd10; step();
        in_en = 1'b0;
        chk("pre_rst_tag", {55'd0, out_tag}, 64'd8);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_en",  {63'd0, out_en},  64'd0);
        chk("rst2_res", out_Res,          64'd0);
        chk("rst2_tag", {55'd0, out_tag}, 64'd0);
        chk("rst2_flg", {58'd0, out_flg}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst2_stale_en",  {63'd0, out_en}, 64'd0);
            chk("rst2_stale_res", out_Res,         64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
